// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the instruction-fetch
// requester (I) and the load/store requester (D). It runs one transfer at a time on a
// bus with an active-low acknowledge, returns read data with a one-cycle done pulse, and
// can abort a transfer whose acknowledge never arrives.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration between I and D.
// Without it, D has fixed priority over I.
module mem_port_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [1:0]  I_SIZE      = 2'b10
) (
    input  logic          clk,
    input  logic          rst,
    // instruction fetch requester
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    // load/store requester
    input  logic          d_req,
    input  logic          d_write,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    // memory bus
    output logic          bus_req,
    output logic          bus_write,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack_n,
    // status
    output logic          err,
    output logic          gnt_d
);

    // Wide enough to hold TIMEOUT_CYC-1, the last waiting cycle before abort.
    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] WAIT_MAX = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StIXfer, StDXfer} state_t;

    state_t        state_q;
    logic [CW-1:0] wait_q;
    logic          pick_d;
    logic          timeout_hit;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;  // 1 when the most recently finished transfer belonged to D

    // Grant selection: alternate on contention, otherwise serve whoever is asking.
    always_comb begin
        pick_d = d_req;
        if (d_req && i_req) begin
            pick_d = !last_d_q;
        end
    end
`else
    // Grant selection: D always beats I.
    always_comb begin
        pick_d = d_req;
    end
`endif

    // Abort once the wait counter has reached its limit with ack still high.
    always_comb begin
        timeout_hit = (TIMEOUT_CYC != 0) && (wait_q == WAIT_MAX);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            i_rdata   <= '0;
            i_done    <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
            err       <= 1'b0;
            gnt_d     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A stray ack while idle is deliberately ignored here.
                    wait_q <= '0;
                    if (pick_d) begin
                        state_q   <= StDXfer;
                        bus_req   <= 1'b1;
                        gnt_d     <= 1'b1;
                        bus_write <= d_write;
                        bus_size  <= d_size;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                    end else if (i_req) begin
                        state_q   <= StIXfer;
                        bus_req   <= 1'b1;
                        gnt_d     <= 1'b0;
                        bus_write <= 1'b0;
                        bus_size  <= I_SIZE;
                        bus_addr  <= i_addr;
                        bus_wdata <= '0;
                    end
                end
                StIXfer, StDXfer: begin
                    // Ack takes precedence over a timeout expiring in the same cycle.
                    if (!bus_ack_n || timeout_hit) begin
                        if (state_q == StDXfer) begin
                            d_done <= 1'b1;
                            if (!bus_ack_n) begin
                                d_rdata <= bus_rdata;
                            end
                        end else begin
                            i_done <= 1'b1;
                            if (!bus_ack_n) begin
                                i_rdata <= bus_rdata;
                            end
                        end
                        err     <= bus_ack_n;
                        bus_req <= 1'b0;
                        gnt_d   <= 1'b0;
                        state_q <= StIdle;
`ifdef MEM_ARB_RR_EN
                        last_d_q <= (state_q == StDXfer);
`endif
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter. Stimulus predicts
// each transfer (grant order, bus fields, duration, result) from the arbitration rules and
// queues it; a bus-slave process answers with queued latencies, and a monitor compares.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;
    localparam logic [1:0]  ISZ = 2'b10;

    logic        clk, rst;
    logic        i_req, i_done, d_req, d_write, d_done;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size, bus_size;
    logic        bus_req, bus_write, bus_ack_n, err, gnt_d;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYC(TO), .I_SIZE(ISZ)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .bus_req(bus_req), .bus_write(bus_write), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack_n(bus_ack_n), .err(err), .gnt_d(gnt_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } bus_t;
    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } slv_t;
    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] rdata;
    } done_t;

    bus_t  bus_q[$];
    slv_t  slv_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_i_rdata = '0;
    logic [31:0] m_d_rdata = '0;
    bit          m_last_d  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict one transfer: bus fields, how long bus_req stays up, and the done result.
    task automatic push_xfer(input bit is_d, input logic wr, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input int lat,
                             input logic [31:0] rd);
        bus_t  b;
        slv_t  s;
        done_t d;
        bit    tmo;
        tmo     = (lat >= int'(TO));
        s.lat   = lat;
        s.rdata = rd;
        b.is_d  = is_d;
        b.wr    = is_d ? wr : 1'b0;
        b.sz    = is_d ? sz : ISZ;
        b.addr  = a;
        b.wdata = is_d ? wd : 32'h0;
        b.len   = tmo ? int'(TO) : lat + 1;
        d.is_d  = is_d;
        d.err   = tmo;
        d.rdata = tmo ? (is_d ? m_d_rdata : m_i_rdata) : rd;
        if (is_d) m_d_rdata = d.rdata;
        else m_i_rdata = d.rdata;
        m_last_d = is_d;
        bus_q.push_back(b);
        slv_q.push_back(s);
        done_q.push_back(d);
    endtask

    // kind: 0 = fetch only, 1 = data only, 2 = both raised together.
    task automatic run_scn(input int kind, input bit churn, input int lat_i, input int lat_d,
                           input logic [31:0] rd_i, input logic [31:0] rd_d,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic dw, input logic [1:0] ds);
        bit d_first;
        int need, got, budget;
        if (kind == 0) begin
            push_xfer(1'b0, 1'b0, 2'b00, ia, 32'h0, lat_i, rd_i);
        end else if (kind == 1) begin
            push_xfer(1'b1, dw, ds, da, wd, lat_d, rd_d);
        end else begin
`ifdef MEM_ARB_RR_EN
            d_first = !m_last_d;
`else
            d_first = 1'b1;
`endif
            if (d_first) begin
                push_xfer(1'b1, dw, ds, da, wd, lat_d, rd_d);
                push_xfer(1'b0, 1'b0, 2'b00, ia, 32'h0, lat_i, rd_i);
            end else begin
                push_xfer(1'b0, 1'b0, 2'b00, ia, 32'h0, lat_i, rd_i);
                push_xfer(1'b1, dw, ds, da, wd, lat_d, rd_d);
            end
        end
        need    = (kind == 2) ? 2 : 1;
        i_addr  = ia;
        d_addr  = da;
        d_wdata = wd;
        d_write = dw;
        d_size  = ds;
        i_req   = (kind != 1);
        d_req   = (kind != 0);
        got     = 0;
        budget  = 0;
        while (got < need && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
            // Requesters drop req in their done cycle so it is not seen as a new request.
            if (i_done) begin
                i_req = 1'b0;
                got++;
            end
            if (d_done) begin
                d_req = 1'b0;
                got++;
            end
            if (churn && bus_req) begin
                i_req   = 1'b0;
                d_req   = 1'b0;
                i_addr  = $urandom;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_write = 1'($urandom);
                d_size  = 2'($urandom);
            end
        end
        if (got < need) begin
            checks++;
            errors++;
            $display("FAIL scenario_done_wait: got %0d done pulses expected %0d", got, need);
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    // Bus slave: acks each transfer after its queued latency, garbage data otherwise.
    slv_t cur_s;
    int   scyc = 0;
    initial begin
        bus_ack_n = 1'b1;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus_ack_n = 1'b1;
                scyc      = 0;
            end else if (bus_req) begin
                if (scyc == 0) begin
                    if (slv_q.size() == 0) begin
                        chk("slave_entry_present", 0, 1);
                        cur_s.lat   = 255;
                        cur_s.rdata = '0;
                    end else begin
                        cur_s = slv_q.pop_front();
                    end
                end
                bus_ack_n = (scyc == cur_s.lat) ? 1'b0 : 1'b1;
                bus_rdata = (scyc == cur_s.lat) ? cur_s.rdata : $urandom;
                scyc++;
            end else begin
                scyc      = 0;
                bus_ack_n = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
    end

    // Monitor: compares bus windows and done pulses against the predicted queues.
    bus_t  cur_b;
    done_t e;
    bit    prev_req = 1'b0;
    int    mcyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            chk("done_exclusive", 64'(i_done && d_done), 0);
            chk("err_only_with_done", 64'(err && !(i_done || d_done)), 0);
            if (bus_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 1, 0);
                    cur_b.is_d = 1'b0; cur_b.wr = 1'b0; cur_b.sz = 2'b00;
                    cur_b.addr = '0; cur_b.wdata = '0; cur_b.len = 0;
                end else begin
                    cur_b = bus_q.pop_front();
                end
                mcyc = 0;
            end
            if (bus_req) begin
                mcyc++;
                chk("bus_addr", bus_addr, cur_b.addr);
                chk("bus_write", bus_write, cur_b.wr);
                chk("bus_size", bus_size, cur_b.sz);
                chk("bus_wdata", bus_wdata, cur_b.wdata);
                chk("gnt_d", gnt_d, cur_b.is_d);
            end else begin
                chk("gnt_d_idle", gnt_d, 0);
            end
            chk("done_at_bus_release", 64'(i_done || d_done), 64'(!bus_req && prev_req));
            if (!bus_req && prev_req) chk("bus_req_cycles", mcyc, cur_b.len);
            if (i_done || d_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_port_is_d", d_done, e.is_d);
                    chk("err", err, e.err);
                    chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                end
            end
            prev_req = bus_req;
        end
    end

    initial begin
        int k, lat_i, lat_d;
        bit ch;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_size = 2'b00;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_err", err, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ignores_ack", bus_req, 0);

        // Directed: fetch, store, contention, timeout, recovery, input churn.
        run_scn(0, 1'b0, 3, 0, 32'h0805_0137, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 1'b0, 2'b00);
        chk("fetch_i_rdata", i_rdata, 32'h0805_0137);
        run_scn(1, 1'b0, 0, 0, 32'h0, 32'h1234_5678, 32'h0, 32'h0002_0004, 32'hDEAD_BEEF,
                1'b1, 2'b00);
        run_scn(2, 1'b0, 1, 1, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0100, 32'h0000_0200,
                32'h0, 1'b0, 2'b10);
        run_scn(1, 1'b0, 0, 255, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0300, 32'h0,
                1'b0, 2'b10);
        chk("timeout_d_rdata_kept", d_rdata, 32'hBBBB_0002);
        run_scn(1, 1'b0, 0, 1, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0000_0304, 32'h0,
                1'b0, 2'b10);
        run_scn(1, 1'b1, 0, 2, 32'h0, 32'h5555_AAAA, 32'h0, 32'h0000_0400, 32'h1111_2222,
                1'b0, 2'b01);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            k     = $urandom_range(0, 2);
            ch    = (k != 2) && ($urandom_range(0, 1) == 1);
            lat_i = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 5);
            lat_d = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 5);
            run_scn(k, ch, lat_i, lat_d, $urandom, $urandom, $urandom, $urandom, $urandom,
                    1'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of a fetch
        run_scn(0, 1'b0, 0, 0, 32'h0F0F_0F0F, 32'h0, 32'h0000_0500, 32'h0, 32'h0, 1'b0, 2'b00);
        push_xfer(1'b0, 1'b0, 2'b00, 32'h0000_0600, 32'h0, 255, 32'h0);
        i_addr = 32'h0000_0600;
        i_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_reset_bus_req", bus_req, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_bus_req", bus_req, 0);
        chk("async_rst_i_done", i_done, 0);
        chk("async_rst_i_rdata", i_rdata, 0);
        chk("async_rst_err", err, 0);
        i_req = 1'b0;
        bus_q.delete();
        done_q.delete();
        m_i_rdata = '0;
        m_d_rdata = '0;
        m_last_d  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_idle", bus_req, 0);
        run_scn(2, 1'b0, 0, 2, $urandom, $urandom, 32'h0000_0700, 32'h0000_0800, 32'h0,
                1'b0, 2'b10);

        repeat (4) @(posedge clk);
        #1;
        chk("bus_q_drained", bus_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("slv_q_drained", slv_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
